// File: rtl/pyrite_bpi_flash_target.sv
// Behavioural BPI parallel-NOR flash target: command decoder, status register,
// word program and block erase over a small backing array that aliases the full address space.
module pyrite_bpi_flash_target #(
  parameter int          DATA_W      = 16,
  parameter int          ADDR_W      = 23,
  parameter int          RGN_W       = 1,
  parameter int          MEM_ADDR_W  = 12,
  parameter int          BLK_ADDR_W  = 8,
  parameter int          PROG_CYCLES = 16,
  parameter logic [15:0] MFR_ID      = 16'h0089,
  parameter logic [15:0] DEV_ID      = 16'h8960
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] flash_dq_i,
  output logic [DATA_W-1:0] flash_dq_o,
  output logic              flash_dq_oe,
  input  logic [ADDR_W-1:0] flash_addr,
  input  logic [RGN_W-1:0]  flash_region,
  input  logic              flash_ce_n,
  input  logic              flash_oe_n,
  input  logic              flash_we_n,
  input  logic              flash_adv_n,
  output logic              busy
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_PROG_SETUP  = 3'd1;
  localparam logic [2:0] S_ERASE_SETUP = 3'd2;
  localparam logic [2:0] S_PROG_BUSY   = 3'd3;
  localparam logic [2:0] S_ERASE_BUSY  = 3'd4;

  localparam logic [1:0] M_ARRAY  = 2'd0;
  localparam logic [1:0] M_STATUS = 2'd1;
  localparam logic [1:0] M_ID     = 2'd2;

  localparam int                    CNT_W     = $clog2(PROG_CYCLES + 1);
  localparam logic [CNT_W-1:0]      PROG_LAST = CNT_W'(PROG_CYCLES - 1);
  localparam logic [MEM_ADDR_W-1:0] BLK_MASK  = MEM_ADDR_W'((1 << BLK_ADDR_W) - 1);
  localparam int                    MEM_WORDS = 1 << MEM_ADDR_W;

  // Array is stored complemented so that power-up zeros read back as erased ones.
  logic [DATA_W-1:0]     mem_n [MEM_WORDS];

  logic [2:0]            state;
  logic [1:0]            mode;
  logic [1:0]            sr_err;
  logic [MEM_ADDR_W-1:0] addr_lat;
  logic [MEM_ADDR_W-1:0] eff_addr;
  logic [MEM_ADDR_W-1:0] erase_base;
  logic [CNT_W-1:0]      prog_cnt;
  logic [BLK_ADDR_W-1:0] erase_idx;
  logic                  we_n_prev;
  logic                  wr_evt;
  logic [7:0]            cmd;
  logic [7:0]            sr;
  logic [DATA_W-1:0]     mem_rd;
  logic                  mem_we;
  logic [MEM_ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0]     mem_wd_n;
  logic [DATA_W-1:0]     rd_src;
  logic [DATA_W-1:0]     rd_data_p1;
  logic                  oe_p1;

  assign eff_addr = flash_adv_n ? addr_lat : MEM_ADDR_W'({flash_region, flash_addr});
  assign wr_evt   = !flash_ce_n && !we_n_prev && flash_we_n;
  assign cmd      = flash_dq_i[7:0];
  assign busy     = (state == S_PROG_BUSY) || (state == S_ERASE_BUSY);
  assign sr       = {!busy, 1'b0, sr_err, 4'b0000};
  assign mem_rd   = ~mem_n[eff_addr];

  always_comb begin
    mem_we   = 1'b0;
    mem_wa   = eff_addr;
    mem_wd_n = ~(mem_rd & flash_dq_i);
    if (state == S_PROG_SETUP && wr_evt) begin
      mem_we = 1'b1;
    end else if (state == S_ERASE_BUSY) begin
      mem_we   = 1'b1;
      mem_wa   = erase_base | MEM_ADDR_W'(erase_idx);
      mem_wd_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_n[mem_wa] <= mem_wd_n;
  end

  always_comb begin
    rd_src = mem_rd;
    if (busy || mode == M_STATUS) rd_src = DATA_W'(sr);
    else if (mode == M_ID)        rd_src = eff_addr[0] ? DATA_W'(DEV_ID) : DATA_W'(MFR_ID);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mode       <= M_ARRAY;
      sr_err     <= 2'b00;
      addr_lat   <= '0;
      erase_base <= '0;
      prog_cnt   <= '0;
      erase_idx  <= '0;
      we_n_prev  <= 1'b1;
    end else begin
      we_n_prev <= flash_we_n;
      if (!flash_adv_n) addr_lat <= eff_addr;
      case (state)
        S_IDLE: begin
          if (wr_evt) begin
            case (cmd)
              8'hFF:        mode   <= M_ARRAY;
              8'h70:        mode   <= M_STATUS;
              8'h90:        mode   <= M_ID;
              8'h50:        sr_err <= 2'b00;
              8'h40, 8'h10: state  <= S_PROG_SETUP;
              8'h20:        state  <= S_ERASE_SETUP;
              default:      ;
            endcase
          end
        end
        S_PROG_SETUP: begin
          if (wr_evt) begin
            state    <= S_PROG_BUSY;
            prog_cnt <= '0;
            mode     <= M_STATUS;
          end
        end
        S_ERASE_SETUP: begin
          if (wr_evt) begin
            mode <= M_STATUS;
            if (cmd == 8'hD0) begin
              erase_base <= eff_addr & ~BLK_MASK;
              erase_idx  <= '0;
              state      <= S_ERASE_BUSY;
            end else begin
              sr_err <= 2'b11;
              state  <= S_IDLE;
            end
          end
        end
        S_PROG_BUSY: begin
          if (prog_cnt == PROG_LAST) state <= S_IDLE;
          else                       prog_cnt <= prog_cnt + 1'b1;
        end
        S_ERASE_BUSY: begin
          // Index stops at the last word of the block instead of wrapping.
          if (&erase_idx) state <= S_IDLE;
          else            erase_idx <= erase_idx + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output register stage (p1): one cycle after the bus sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_p1 <= '0;
      oe_p1      <= 1'b0;
    end else begin
      rd_data_p1 <= rd_src;
      oe_p1      <= !flash_ce_n && !flash_oe_n && flash_we_n && !wr_evt;
    end
  end

  assign flash_dq_o  = rd_data_p1;
  assign flash_dq_oe = oe_p1;

endmodule

// File: tb/tb_pyrite_bpi_flash_target.sv
// Bench for pyrite_bpi_flash_target: directed vector table, corner-case sequences,
// then random command traffic checked against a transaction-level flash model.
module tb_pyrite_bpi_flash_target;

  localparam int OP_WR = 0;
  localparam int OP_RD = 1;
  localparam int OP_BZ = 2;
  localparam int PROG  = 16;
  localparam int ERASE = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] dq_i;
  logic [15:0] dq_o;
  logic        dq_oe;
  logic [22:0] addr;
  logic [0:0]  region;
  logic        ce_n, oe_n, we_n, adv_n;
  logic        busy;

  pyrite_bpi_flash_target dut (
    .clk(clk), .rst_n(rst_n),
    .flash_dq_i(dq_i), .flash_dq_o(dq_o), .flash_dq_oe(dq_oe),
    .flash_addr(addr), .flash_region(region),
    .flash_ce_n(ce_n), .flash_oe_n(oe_n), .flash_we_n(we_n), .flash_adv_n(adv_n),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          op;
    logic [23:0] a;
    logic [15:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  // Transaction-level flash model: array contents, read mode, error bits, pending setup.
  logic [15:0] mdl_mem [4096];
  int          mdl_mode;
  logic [1:0]  mdl_sr;
  int          mdl_pend;
  int          mdl_busy_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int op, input logic [23:0] a, input logic [15:0] d, input logic [31:0] e);
    vec_t v;
    v.op = op; v.a = a; v.d = d; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic bus_write(input logic [23:0] a, input logic [15:0] d);
    {region, addr} = a;
    adv_n = 1'b0; dq_i = d; ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0;
    tick();
    we_n = 1'b1;
    tick();
    ce_n = 1'b1; adv_n = 1'b1;
  endtask

  task automatic bus_read(input logic [23:0] a, output logic [15:0] d, output logic oe);
    {region, addr} = a;
    adv_n = 1'b0; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    tick();
    d = dq_o; oe = dq_oe;
    ce_n = 1'b1; oe_n = 1'b1; adv_n = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [23:0] a, input logic [15:0] exp);
    logic [15:0] d;
    logic        oe;
    bus_read(a, d, oe);
    chk({name, "_data"}, 32'(d), 32'(exp));
    chk({name, "_oe"}, 32'(oe), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int exp);
    int n = 0;
    while (busy && n < 5000) begin
      n++;
      tick();
    end
    chk(name, 32'(n), 32'(exp));
  endtask

  task automatic flush_busy();
    if (mdl_busy_exp != 0) begin
      wait_idle("busy_len", mdl_busy_exp);
      mdl_busy_exp = 0;
    end
  endtask

  task automatic model_cmd(input logic [23:0] a, input logic [15:0] d);
    logic [11:0] base;
    if (mdl_pend == 1) begin
      mdl_mem[a[11:0]] = mdl_mem[a[11:0]] & d;
      mdl_mode = 1; mdl_pend = 0; mdl_busy_exp = PROG;
    end else if (mdl_pend == 2) begin
      mdl_mode = 1; mdl_pend = 0;
      if (d[7:0] == 8'hD0) begin
        base = {a[11:8], 8'h00};
        for (int i = 0; i < ERASE; i++) mdl_mem[base + 12'(i)] = 16'hFFFF;
        mdl_busy_exp = ERASE;
      end else begin
        mdl_sr = 2'b11;
      end
    end else begin
      case (d[7:0])
        8'hFF:        mdl_mode = 0;
        8'h70:        mdl_mode = 1;
        8'h90:        mdl_mode = 2;
        8'h50:        mdl_sr   = 2'b00;
        8'h40, 8'h10: mdl_pend = 1;
        8'h20:        mdl_pend = 2;
        default:      ;
      endcase
    end
  endtask

  function automatic logic [15:0] mdl_read(input logic [23:0] a);
    if (mdl_mode == 1) return {8'h00, 1'b1, 1'b0, mdl_sr, 4'h0};
    if (mdl_mode == 2) return a[0] ? 16'h8960 : 16'h0089;
    return mdl_mem[a[11:0]];
  endfunction

  task automatic host_write(input logic [23:0] a, input logic [15:0] d);
    flush_busy();
    bus_write(a, d);
    model_cmd(a, d);
  endtask

  initial begin
    logic [15:0] d;
    logic        oe;
    logic [23:0] a;
    logic [7:0]  b;
    int          r;

    rst_n = 1'b0; ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; adv_n = 1'b1;
    addr = '0; region = '0; dq_i = '0;
    for (int i = 0; i < 4096; i++) mdl_mem[i] = 16'hFFFF;
    mdl_mode = 0; mdl_sr = 2'b00; mdl_pend = 0; mdl_busy_exp = 0;

    add(OP_RD, 24'h000010, 16'h0000, 32'hFFFF);
    add(OP_WR, 24'h000010, 16'h0040, 0);
    add(OP_WR, 24'h000010, 16'h1234, 0);
    add(OP_BZ, 24'h000000, 16'h0000, PROG);
    add(OP_RD, 24'h000010, 16'h0000, 32'h0080);
    add(OP_WR, 24'h000010, 16'h00FF, 0);
    add(OP_RD, 24'h000010, 16'h0000, 32'h1234);
    add(OP_WR, 24'h000010, 16'h0010, 0);
    add(OP_WR, 24'h000010, 16'hFF0F, 0);
    add(OP_BZ, 24'h000000, 16'h0000, PROG);
    add(OP_WR, 24'h000000, 16'h00FF, 0);
    add(OP_RD, 24'h000010, 16'h0000, 32'h1204);
    add(OP_WR, 24'h000200, 16'h0040, 0);
    add(OP_WR, 24'h000200, 16'hABCD, 0);
    add(OP_BZ, 24'h000000, 16'h0000, PROG);
    add(OP_WR, 24'h000150, 16'h0040, 0);
    add(OP_WR, 24'h000150, 16'h0F0F, 0);
    add(OP_BZ, 24'h000000, 16'h0000, PROG);
    add(OP_WR, 24'h000123, 16'h0020, 0);
    add(OP_WR, 24'h000123, 16'h00D0, 0);
    add(OP_BZ, 24'h000000, 16'h0000, ERASE);
    add(OP_WR, 24'h000000, 16'h00FF, 0);
    add(OP_RD, 24'h000100, 16'h0000, 32'hFFFF);
    add(OP_RD, 24'h000150, 16'h0000, 32'hFFFF);
    add(OP_RD, 24'h0001FF, 16'h0000, 32'hFFFF);
    add(OP_RD, 24'h000200, 16'h0000, 32'hABCD);
    add(OP_RD, 24'h000010, 16'h0000, 32'h1204);
    add(OP_WR, 24'h000000, 16'h0020, 0);
    add(OP_WR, 24'h000000, 16'h0055, 0);
    add(OP_RD, 24'h000000, 16'h0000, 32'h00B0);
    add(OP_WR, 24'h000000, 16'h0050, 0);
    add(OP_RD, 24'h000000, 16'h0000, 32'h0080);
    add(OP_WR, 24'h000000, 16'h0090, 0);
    add(OP_RD, 24'h000000, 16'h0000, 32'h0089);
    add(OP_RD, 24'h000001, 16'h0000, 32'h8960);
    add(OP_RD, 24'h000011, 16'h0000, 32'h8960);
    add(OP_WR, 24'h000000, 16'h00FF, 0);
    add(OP_RD, 24'h001010, 16'h0000, 32'h1204);
    add(OP_RD, 24'h801010, 16'h0000, 32'h1204);
    add(OP_WR, 24'h000000, 16'hAB70, 0);
    add(OP_RD, 24'h000010, 16'h0000, 32'h0080);
    add(OP_WR, 24'h000000, 16'h0033, 0);
    add(OP_RD, 24'h000010, 16'h0000, 32'h0080);
    add(OP_WR, 24'h000000, 16'h00FF, 0);
    add(OP_RD, 24'h000010, 16'h0000, 32'h1204);

    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_oe", 32'(dq_oe), 32'd0);
    chk("rst_dq", 32'(dq_o), 32'd0);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      case (tbl[i].op)
        OP_WR: host_write(tbl[i].a, tbl[i].d);
        OP_RD: rd_chk($sformatf("tbl%0d", i), tbl[i].a, tbl[i].exp[15:0]);
        default: begin
          wait_idle($sformatf("tbl%0d_busy", i), int'(tbl[i].exp));
          mdl_busy_exp = 0;
        end
      endcase
    end

    // Status during busy, and a command written while busy must be dropped.
    host_write(24'h000020, 16'h0040);
    host_write(24'h000020, 16'h5555);
    bus_read(24'h000020, d, oe);
    chk("busy_status", 32'(d), 32'h0000);
    bus_write(24'h000020, 16'h0040);
    wait_idle("busy_rest", PROG - 3);
    mdl_busy_exp = 0;
    host_write(24'h000020, 16'h0000);
    host_write(24'h000000, 16'h00FF);
    rd_chk("busy_wr_ignored", 24'h000020, 16'h5555);

    // oe_n low on the write-event cycle keeps the drive off; next plain read cycle drives.
    {region, addr} = 24'h000010;
    adv_n = 1'b0; dq_i = 16'h00FF; ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0;
    tick();
    we_n = 1'b1; oe_n = 1'b0;
    tick();
    chk("oe_on_wr_evt", 32'(dq_oe), 32'd0);
    model_cmd(24'h000010, 16'h00FF);
    tick();
    chk("oe_after_wr", 32'(dq_oe), 32'd1);
    chk("dq_after_wr", 32'(dq_o), 32'h1204);
    ce_n = 1'b1; oe_n = 1'b1; adv_n = 1'b1;

    // Deselected chip: no drive, and strobed commands are ignored.
    oe_n = 1'b0; ce_n = 1'b1;
    tick();
    chk("ce_hi_oe", 32'(dq_oe), 32'd0);
    oe_n = 1'b1; dq_i = 16'h0090; we_n = 1'b0;
    tick();
    we_n = 1'b1;
    tick();
    rd_chk("ce_hi_wr", 24'h000010, 16'h1204);

    // Reset in the middle of a block erase.
    host_write(24'h000405, 16'h0040);
    host_write(24'h000405, 16'h1234);
    host_write(24'h0004C8, 16'h0040);
    host_write(24'h0004C8, 16'h5678);
    host_write(24'h000000, 16'h00FF);
    flush_busy();
    bus_write(24'h000400, 16'h0020);
    bus_write(24'h000400, 16'h00D0);
    repeat (50) tick();
    chk("erase_mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_oe", 32'(dq_oe), 32'd0);
    chk("abort_dq", 32'(dq_o), 32'd0);
    tick();
    chk("abort_busy_hold", 32'(busy), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) mdl_mem[12'h400 + 12'(i)] = 16'hFFFF;
    mdl_mode = 0; mdl_sr = 2'b00; mdl_pend = 0; mdl_busy_exp = 0;
    rd_chk("abort_erased", 24'h000405, 16'hFFFF);
    rd_chk("abort_kept", 24'h0004C8, 16'h5678);
    rd_chk("abort_edge", 24'h000431, mdl_read(24'h000431));

    // Random command traffic against the model.
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 11);
      a = 24'($urandom);
      case (r)
        0, 1: begin
          host_write(a, (r == 0) ? 16'h0040 : 16'h0010);
          host_write(a, 16'($urandom));
        end
        5: host_write(a, 16'h00FF);
        6: host_write(a, 16'h0070);
        7: host_write(a, 16'h0090);
        8: host_write(a, 16'h0050);
        9: begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'hD0) b = 8'hD1;
          host_write(a, 16'h0020);
          host_write(a, {8'($urandom), b});
        end
        10: host_write(a, 16'($urandom));
        11: begin
          if ($urandom_range(0, 3) == 0) begin
            host_write(a, 16'h0020);
            host_write(a, 16'h00D0);
          end else begin
            rd_chk("rand_rd", a, mdl_read(a));
          end
        end
        default: rd_chk("rand_rd", a, mdl_read(a));
      endcase
      flush_busy();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
